// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative divider (mdu_div).
// Signed-division support is controlled by the MDU_SIGNED_DIV_EN macro in mdu_div.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Quotient reported for a zero divisor; sliced down to WIDTH (WIDTH <= 64).
  localparam logic [63:0] DIV0_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The partial remainder is always below the divisor, so diff[WIDTH] is the borrow.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign borrow   = diff[WIDTH];
  assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/mdu_div.sv
// Multi-cycle restoring divider (div/divu); 34-cycle latency, 1 cycle on divide-by-zero.
// Define MDU_SIGNED_DIV_EN to enable signed division; otherwise is_signed is ignored.
module mdu_div
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

`ifdef MDU_SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             neg_q, neg_r, div_zero_q;
  logic             signed_req, dvd_neg, dvs_neg, accept, div0;

  assign signed_req = SIGNED_EN & is_signed;
  assign dvd_neg    = signed_req & dividend[WIDTH-1];
  assign dvs_neg    = signed_req & divisor[WIDTH-1];
  assign dvd_mag    = dvd_neg ? -dividend : dividend;
  assign dvs_mag    = dvs_neg ? -divisor : divisor;
  assign accept     = (state == IDLE) && start;
  assign div0       = (divisor == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = div0 ? DONE : RUN;
      RUN:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Working registers double as the result outputs; FIX applies the signs in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= '0;
            div_zero_q <= div0;
            if (div0) begin
              quo_q <= DIV0_QUOTIENT[WIDTH-1:0];
              rem_q <= dividend;
              dvs_q <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo_q <= dvd_mag;
              rem_q <= '0;
              dvs_q <= dvs_mag;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
            end
          end
        end
        RUN: begin
          quo_q <= step_quo;
          rem_q <= step_rem;
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          if (neg_q) quo_q <= -quo_q;
          if (neg_r) rem_q <= -rem_q;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_mdu_div.sv
// Directed self-checking bench for mdu_div; expectations follow MDU_SIGNED_DIV_EN.
module tb_mdu_div;

`ifdef MDU_SIGNED_DIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_div #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // Drives start in cycle N; returns just after the edge that samples it (cycle N+1).
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle offset (from N) of the first done, or -1; also counts cycles with busy low before it.
  task automatic wait_done(input int limit, output int cyc, output int busy_low);
    cyc      = -1;
    busy_low = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("[TB] FAIL reset_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("[TB] FAIL reset_remainder got=%h exp=0", remainder); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_div_zero got=%b exp=0", div_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int cyc, bl;
    applyStimulus(1'b0, 32'd100, 32'd7);
    wait_done(60, cyc, bl);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL udiv_latency got=%0d exp=34", cyc); end
    checks++; if (bl !== 0) begin errors++; $display("[TB] FAIL udiv_busy_gaps got=%0d exp=0", bl); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL udiv_quotient got=%h exp=%h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("[TB] FAIL udiv_remainder got=%h exp=%h", remainder, 32'd2); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL udiv_div_zero got=%b exp=0", div_zero); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL udiv_after_done done=%b busy=%b exp=0 0", done, busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL udiv_hold got=%h exp=%h", quotient, 32'd14); end
  endtask

  task automatic test_signed();
    int cyc, bl;
    logic [31:0] exp_q, exp_r;
    exp_q = SIGNED_EN ? 32'hFFFF_FFF2 : 32'h2492_4916;
    exp_r = SIGNED_EN ? 32'hFFFF_FFFE : 32'h0000_0002;
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(60, cyc, bl);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL sdiv_latency got=%0d exp=34", cyc); end
    checks++; if (quotient !== exp_q) begin errors++; $display("[TB] FAIL sdiv_quotient got=%h exp=%h", quotient, exp_q); end
    checks++; if (remainder !== exp_r) begin errors++; $display("[TB] FAIL sdiv_remainder got=%h exp=%h", remainder, exp_r); end
  endtask

  task automatic test_div_zero();
    int cyc, bl;
    applyStimulus(1'b0, 32'h1234_5678, 32'h0);
    wait_done(60, cyc, bl);
    checks++; if (cyc !== 1) begin errors++; $display("[TB] FAIL dz_latency got=%0d exp=1", cyc); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("[TB] FAIL dz_flag got=%b exp=1", div_zero); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL dz_quotient got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'h1234_5678) begin errors++; $display("[TB] FAIL dz_remainder got=%h exp=12345678", remainder); end
  endtask

  task automatic test_overflow();
    int cyc, bl;
    logic [31:0] exp_q, exp_r;
    exp_q = SIGNED_EN ? 32'h8000_0000 : 32'h0000_0000;
    exp_r = SIGNED_EN ? 32'h0000_0000 : 32'h8000_0000;
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(60, cyc, bl);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL ovf_latency got=%0d exp=34", cyc); end
    checks++; if (quotient !== exp_q) begin errors++; $display("[TB] FAIL ovf_quotient got=%h exp=%h", quotient, exp_q); end
    checks++; if (remainder !== exp_r) begin errors++; $display("[TB] FAIL ovf_remainder got=%h exp=%h", remainder, exp_r); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("[TB] FAIL ovf_div_zero_cleared got=%b exp=0", div_zero); end
  endtask

  task automatic test_back_to_back();
    int cyc, bl;
    applyStimulus(1'b0, 32'd1000, 32'd3);
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 34) begin
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_n34 got=%b exp=1", done); end
      end
      if (c == 35) begin
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_n35 done=%b busy=%b exp=0 0", done, busy); end
        checks++; if (quotient !== 32'd333 || remainder !== 32'd1 || div_zero !== 1'b0) begin
          errors++; $display("[TB] FAIL b2b_unchanged q=%h r=%h dz=%b exp=%h %h 0", quotient, remainder, div_zero, 32'd333, 32'd1);
        end
      end
      start = (c == 5 || c == 34 || c == 35);
      dividend = (c == 35) ? 32'd50 : 32'd77;
      divisor  = (c == 35) ? 32'd5 : 32'd0;
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(60, cyc, bl);
    checks++; if (cyc !== 34) begin errors++; $display("[TB] FAIL b2b_new_latency got=%0d exp=34", cyc); end
    checks++; if (quotient !== 32'd10 || remainder !== 32'd0) begin errors++; $display("[TB] FAIL b2b_new_result q=%h r=%h exp=a 0", quotient, remainder); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bl;
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_ctrl busy=%b done=%b exp=0 0", busy, done); end
    checks++; if (quotient !== 32'h0 || remainder !== 32'h0 || div_zero !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_data q=%h r=%h dz=%b exp=0 0 0", quotient, remainder, div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(40, cyc, bl);
    checks++; if (cyc !== -1) begin errors++; $display("[TB] FAIL rst_mid_no_done got=%0d exp=-1", cyc); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a division, accepted only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1, selecting div (1) or divu (0), sampled with start.
REQ-006 The block SHALL have port dividend, input, WIDTH, the numerator, sampled with start.
REQ-007 The block SHALL have port divisor, input, WIDTH, the denominator, sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse marking valid results.
REQ-010 The block SHALL have port quotient, output, WIDTH, the LO result.
REQ-011 The block SHALL have port remainder, output, WIDTH, the HI result.
REQ-012 The block SHALL have port div_zero, output, 1, set with done when divisor was zero.

Function
REQ-013 The state machine SHALL have states IDLE, RUN, FIX and DONE; after reset it SHALL be in IDLE.
- IDLE to RUN on start with a nonzero divisor.
- IDLE to DONE on start with a zero divisor.
- RUN to FIX after WIDTH iterations.
- FIX to DONE unconditionally.
- DONE to IDLE unconditionally.
REQ-014 In IDLE, on start, the block SHALL latch operand magnitudes, the sign flags and is_signed, and SHALL clear the iteration counter and partial remainder.
REQ-015 The RUN state SHALL perform one restoring step per cycle.
- Shift the {remainder, quotient} pair left by one.
- Trial-subtract the divisor from the partial remainder using a WIDTH+1-bit subtract.
- If no borrow, keep the difference and set quotient bit 0 to 1; otherwise restore the remainder and set quotient bit 0 to 0.
REQ-016 With start sampled in cycle N and a nonzero divisor, done SHALL be high in cycle N+34 only, and busy SHALL be high in cycles N+1 through N+34.
REQ-017 With a zero divisor, done and div_zero SHALL be high in cycle N+1, quotient SHALL be all ones, and remainder SHALL equal the dividend.
REQ-018 quotient and remainder SHALL hold their values from done until the next accepted start.
REQ-019 A start while busy SHALL be ignored, including a start in the DONE cycle; the operand inputs SHALL be don't-care whenever start is not being accepted.
REQ-020 In FIX, for a signed division, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-021 A signed division of 0x80000000 by 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no flag raised.
REQ-022 div_zero SHALL clear on the next accepted start.

Reset
REQ-023 While rst_n is low, the state SHALL be IDLE and busy, done, div_zero, quotient, remainder and the counter SHALL all be 0, regardless of clk.
REQ-024 Reset asserted mid-RUN SHALL abort the operation, and no done SHALL be produced for it.

Configuration
REQ-025 The macro MDU_SIGNED_DIV_EN SHALL control signed division support.
- Defined: is_signed SHALL operate as specified above.
- Undefined: is_signed SHALL be ignored, all divisions SHALL be unsigned, FIX SHALL pass results through unchanged, and latency SHALL remain 34 cycles.

Structure
REQ-026 A shared package mdu_pkg SHALL hold the state encoding type, WIDTH-derived counter width, and the divide-by-zero result constants.
REQ-027 A sub-module div_step SHALL implement the combinational shift, trial-subtract and restore for one iteration.

Verification
REQ-028 The bench SHALL cover the following directed scenarios.
- Unsigned 100 / 7 -> done at N+34, quotient 14, remainder 2, div_zero 0.
- Signed -100 / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); with MDU_SIGNED_DIV_EN undefined -> unsigned result of 0xFFFFFF9C / 7.
- Divisor 0, dividend 0x12345678 -> done and div_zero at N+1, quotient 0xFFFFFFFF, remainder 0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- start pulsed at N+5 and in the DONE cycle -> ignored; results unchanged; a new start at N+35 is accepted.
- rst_n low at N+10 -> busy 0 immediately, no done pulse, all outputs 0.
